// File: rtl/otp_pkg.sv
// otp_pkg: shared types, mode constants and LFSR step for the OTP stream cipher
//   state_t      : pad-register state (NOKEY, ARMED)
//   MODE_*       : pad usage modes (one-time / rolling)
//   lfsr_next()  : one Galois LFSR step on a zero-extended pad (WIDTH <= LFSR_W)
package otp_pkg;
   typedef enum logic {NOKEY = 1'b0, ARMED = 1'b1} state_t;
   localparam logic MODE_ONETIME = 1'b0;
   localparam logic MODE_ROLLING = 1'b1;
   localparam int LFSR_W = 64;
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] pad, input logic [LFSR_W-1:0] taps);
      return (pad >> 1) ^ (pad[0] ? taps : '0);
   endfunction
endpackage

// File: rtl/otp_stream_cipher_if.sv
// otp_stream_cipher_if: plaintext-in / ciphertext-out valid-ready streaming bus
//   in_valid/in_ready/in_data    : plaintext handshake (master drives valid/data)
//   out_valid/out_ready/out_data : ciphertext handshake (master drives ready)
//   master : source/sink side, slave : cipher side
interface otp_stream_cipher_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
   modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/otp_pad_reg.sv
// otp_pad_reg: secret pad, mode and use counter with zeroize > load > advance priority
//   clk, reset_n      : clock, asynchronous active-low reset
//   key_load/key_in/mode_in : load a new pad and mode (zero key disarms)
//   zeroize           : destroy pad and clear use count
//   advance           : one word was encrypted with the current pad
//   pad, armed, uses  : current pad, pad usable, saturating word count
module otp_pad_reg
   import otp_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] KEY_RESET  = 8'h5A,
   parameter logic             MODE_RESET = 1'b1,
   parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
   parameter logic [15:0]      MAX_USES   = 16'hFFFF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             key_load,
   input  logic [WIDTH-1:0] key_in,
   input  logic             mode_in,
   input  logic             zeroize,
   input  logic             advance,
   output logic [WIDTH-1:0] pad,
   output logic             armed,
   output logic [15:0]      uses
);
   state_t           state;
   logic             mode;
   logic [15:0]      uses_inc;
   logic [WIDTH-1:0] pad_next;
   assign uses_inc = (uses == 16'hFFFF) ? uses : uses + 16'd1;
   assign pad_next = WIDTH'(lfsr_next(LFSR_W'(pad), LFSR_W'(TAPS)));
   assign armed    = (state == ARMED);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= (KEY_RESET != '0) ? ARMED : NOKEY;
         pad   <= KEY_RESET;
         mode  <= MODE_RESET;
         uses  <= '0;
      end else if (zeroize) begin
         state <= NOKEY;
         pad   <= '0;
         uses  <= '0;
      end else if (key_load) begin
         if (key_in != '0) begin
            state <= ARMED;
            pad   <= key_in;
            mode  <= mode_in;
            uses  <= '0;
         end else begin
            // a zero pad would pass plaintext through, so it is never armed
            state <= NOKEY;
            pad   <= '0;
            if (advance) uses <= uses_inc;
         end
      end else if (advance) begin
         uses <= uses_inc;
         if (mode == MODE_ONETIME || uses_inc == MAX_USES) begin
            state <= NOKEY;
            pad   <= '0;
         end else begin
            pad <= pad_next;
         end
      end
   end
endmodule

// File: rtl/otp_stream_cipher.sv
// otp_stream_cipher: XOR stream encryptor with one-time / rolling pad and zeroize
//   clk, reset_n   : clock, asynchronous active-low reset
//   key_load, key_in, mode_in : load a new pad and its usage mode
//   zeroize        : destroy pad and flush any pending ciphertext
//   bus            : plaintext in / ciphertext out valid-ready streams
//   armed, uses    : pad usable, words encrypted with current pad
module otp_stream_cipher
   import otp_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] KEY_RESET  = 8'h5A,
   parameter logic             MODE_RESET = 1'b1,
   parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
   parameter logic [15:0]      MAX_USES   = 16'hFFFF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 key_load,
   input  logic [WIDTH-1:0]     key_in,
   input  logic                 mode_in,
   input  logic                 zeroize,
   otp_stream_cipher_if.slave   bus,
   output logic                 armed,
   output logic [15:0]          uses
);
   logic [WIDTH-1:0] pad;
   logic             accept;
   assign bus.in_ready = armed && (!bus.out_valid || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   otp_pad_reg #(
      .WIDTH(WIDTH), .KEY_RESET(KEY_RESET), .MODE_RESET(MODE_RESET), .TAPS(TAPS), .MAX_USES(MAX_USES)
   ) u_pad (
      .clk(clk), .reset_n(reset_n), .key_load(key_load), .key_in(key_in), .mode_in(mode_in),
      .zeroize(zeroize), .advance(accept && !zeroize), .pad(pad), .armed(armed), .uses(uses)
   );
   // out_data is cleared on every path that drops out_valid, so it reads 0 when idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
      end else if (zeroize) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= bus.in_data ^ pad;
      end else if (bus.out_valid && bus.out_ready) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
      end
   end
endmodule

// File: tb/tb_otp_stream_cipher.sv
// tb_otp_stream_cipher: directed self-checking bench for otp_stream_cipher
module tb_otp_stream_cipher;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        key_load, mode_in, zeroize;
   logic [7:0]  key_in;
   logic        armed, armed2;
   logic [15:0] uses, uses2;
   logic        key_load2 = 1'b0, mode_in2 = 1'b0, zeroize2 = 1'b0;
   logic [7:0]  key_in2 = 8'h00;
   int          checks = 0;
   int          failures = 0;
   otp_stream_cipher_if #(.WIDTH(8)) bus ();
   otp_stream_cipher_if #(.WIDTH(8)) bus2 ();
   otp_stream_cipher dut (
      .clk(clk), .reset_n(reset_n), .key_load(key_load), .key_in(key_in), .mode_in(mode_in),
      .zeroize(zeroize), .bus(bus), .armed(armed), .uses(uses)
   );
   otp_stream_cipher #(.MAX_USES(16'd2)) dut2 (
      .clk(clk), .reset_n(reset_n), .key_load(key_load2), .key_in(key_in2), .mode_in(mode_in2),
      .zeroize(zeroize2), .bus(bus2), .armed(armed2), .uses(uses2)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic expect_out(input string tag, input logic v, input logic [7:0] d);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
      check({tag, "_data"}, 32'(bus.out_data), 32'(d));
   endtask
   initial begin
      reset_n = 1'b0; key_load = 0; key_in = 0; mode_in = 0; zeroize = 0;
      bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
      bus2.in_valid = 0; bus2.in_data = 0; bus2.out_ready = 0;
      step(); step();
      check("rst_armed", 32'(armed), 1);
      expect_out("rst_out", 0, 8'h00);
      check("rst_uses", 32'(uses), 0);
      check("rst_in_ready", 32'(bus.in_ready), 1);
      reset_n = 1'b1;
      step();
      // rolling stream from reset pad 5A
      bus.out_ready = 1; bus.in_valid = 1; bus.in_data = 8'h00;
      step(); expect_out("roll0", 1, 8'h5A);
      step(); expect_out("roll1", 1, 8'h2D);
      step(); expect_out("roll2", 1, 8'hAE);
      bus.in_valid = 0;
      step(); expect_out("roll_drain", 0, 8'h00);
      check("roll_uses", 32'(uses), 3);
      // backpressure: pad 57 used, held while stalled
      bus.in_valid = 1; bus.out_ready = 0;
      step(); expect_out("bp_first", 1, 8'h57);
      for (int i = 0; i < 4; i++) begin
         step();
         expect_out("bp_hold", 1, 8'h57);
         check("bp_in_ready", 32'(bus.in_ready), 0);
         check("bp_uses", 32'(uses), 4);
      end
      bus.out_ready = 1;
      step(); expect_out("bp_release", 1, 8'h93);
      bus.in_valid = 0;
      step(); expect_out("bp_drain", 0, 8'h00);
      // accept with key_load: old pad F1 encrypts, new pad 11 next
      key_load = 1; key_in = 8'h11; mode_in = 1; bus.in_valid = 1; bus.in_data = 8'h00;
      step(); expect_out("kl_old", 1, 8'hF1);
      check("kl_uses", 32'(uses), 0);
      key_load = 0;
      step(); expect_out("kl_new", 1, 8'h11);
      check("kl_uses1", 32'(uses), 1);
      bus.in_valid = 0;
      step();
      // one-time pad 3C
      key_load = 1; key_in = 8'h3C; mode_in = 0;
      step(); key_load = 0;
      check("ot_armed", 32'(armed), 1);
      bus.in_valid = 1; bus.in_data = 8'h5A;
      step(); expect_out("ot_word", 1, 8'h66);
      check("ot_disarm", 32'(armed), 0);
      check("ot_in_ready", 32'(bus.in_ready), 0);
      step(); expect_out("ot_ignored", 0, 8'h00);
      step(); expect_out("ot_ignored2", 0, 8'h00);
      check("ot_uses", 32'(uses), 1);
      bus.in_valid = 0;
      // zeroize with a pending word
      key_load = 1; key_in = 8'h22; mode_in = 1;
      step(); key_load = 0;
      bus.in_valid = 1; bus.in_data = 8'h00; bus.out_ready = 0;
      step(); expect_out("zz_pending", 1, 8'h22);
      bus.in_valid = 0; zeroize = 1;
      step(); zeroize = 0;
      expect_out("zz_flush", 0, 8'h00);
      check("zz_armed", 32'(armed), 0);
      check("zz_uses", 32'(uses), 0);
      key_load = 1; key_in = 8'h00;
      step(); key_load = 0;
      check("zero_key_armed", 32'(armed), 0);
      check("zero_key_in_ready", 32'(bus.in_ready), 0);
      // MAX_USES=2 exhaustion on second instance
      bus2.in_valid = 1; bus2.in_data = 8'h00; bus2.out_ready = 1;
      step();
      check("mx_w0", 32'(bus2.out_data), 32'h5A);
      check("mx_armed0", 32'(armed2), 1);
      step();
      check("mx_w1", 32'(bus2.out_data), 32'h2D);
      check("mx_armed1", 32'(armed2), 0);
      check("mx_uses", 32'(uses2), 2);
      bus2.in_valid = 0;
      // async reset mid-stream
      bus.out_ready = 0; key_load = 1; key_in = 8'h44; mode_in = 1;
      step(); key_load = 0; bus.in_valid = 1;
      step(); expect_out("ar_pending", 1, 8'h44);
      #2 reset_n = 1'b0;
      #1;
      expect_out("ar_drop", 0, 8'h00);
      check("ar_armed", 32'(armed), 1);
      #3 reset_n = 1'b1;
      bus.out_ready = 1; bus.in_valid = 1; bus.in_data = 8'h00;
      step(); expect_out("ar_recover", 1, 8'h5A);
      bus.in_valid = 0;
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
